// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: merges the pipeline WB stage and a 2-deep aux result buffer onto one register-file write port.
// Latency: one cycle from grant to the registered rf_* outputs; an aux result reaches the FIFO head the cycle after it is pushed.
// Backpressure: pipe_ack drops in a forced aux cycle so the pipeline holds its entry; aux_ready drops while the buffer holds two entries.
//
// Ports:
//   clk, reset                      single clock, synchronous active-high reset
//   pipe_valid/pipe_rd/pipe_data    pipeline WB result; pipe_ack is its combinational consume strobe
//   aux_valid/aux_rd/aux_data       multi-cycle unit result; aux_ready is the buffer-accept strobe
//   rf_we/rf_rd/rf_wdata/rf_src     registered register-file write port (rf_src: 0 = pipe, 1 = aux)

// Small synchronous FIFO. Push into a full FIFO or pop from an empty one is ignored.
// Latency: a pushed entry appears at head_dat the cycle after the push.
// Backpressure: none internally; the owner gates push using count.
module wb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_push  = push && (count != CW'(DEPTH));
  assign do_pop   = pop && (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  output logic        pipe_ack,
  input  logic        aux_valid,
  input  logic [4:0]  aux_rd,
  input  logic [31:0] aux_data,
  output logic        aux_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        rf_src
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } state_t;

  localparam int         AUX_DEPTH = 2;
  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] starve_cnt;
  logic [3:0] starve_nxt;

  wb_ent_t    aux_in;
  wb_ent_t    aux_head;
  logic [1:0] fifo_count;
  logic       aux_avail;
  logic       aux_push;
  logic       grant_pipe;
  logic       grant_aux;

  // Readiness looks only at the current occupancy: a pop in the same cycle
  // does not reopen a full buffer, which keeps aux_ready off the grant path.
  assign aux_ready = !reset && (fifo_count < 2'd2);
  assign aux_push  = aux_valid && aux_ready;
  assign aux_in    = '{rd: aux_rd, data: aux_data};
  assign aux_avail = (fifo_count != 2'd0);

  wb_sync_fifo #(
    .WIDTH ($bits(wb_ent_t)),
    .DEPTH (AUX_DEPTH)
  ) u_aux_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (aux_push),
    .push_dat (aux_in),
    .pop      (grant_aux),
    .head_dat (aux_head),
    .count    (fifo_count)
  );

  assign pipe_ack = pipe_valid && (state == NORMAL);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= NORMAL;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Pipe normally wins. Each cycle a buffered aux result is passed over
  // counts toward the limit; on the cycle the count reaches it the next
  // cycle is a one-shot FORCE that drains the head and stalls the pipe.
  always_comb begin
    grant_pipe = 1'b0;
    grant_aux  = 1'b0;
    state_nxt  = NORMAL;
    starve_nxt = '0;

    case (state)
      FORCE: begin
        grant_aux = aux_avail;
      end
      default: begin
        if (pipe_valid) begin
          grant_pipe = 1'b1;
        end else if (aux_avail) begin
          grant_aux = 1'b1;
        end
      end
    endcase

    if (aux_avail && !grant_aux) begin
      starve_nxt = starve_cnt + 4'd1;
      if (starve_nxt == LIMIT) begin
        state_nxt = FORCE;
      end
    end
  end

  // Writes to x0 are consumed like any other result but never assert rf_we.
  // Idle cycles keep the last address/data/source on the port.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      rf_src   <= 1'b0;
    end else if (grant_pipe) begin
      rf_we    <= (pipe_rd != 5'd0);
      rf_rd    <= pipe_rd;
      rf_wdata <= pipe_data;
      rf_src   <= 1'b0;
    end else if (grant_aux) begin
      rf_we    <= (aux_head.rd != 5'd0);
      rf_rd    <= aux_head.rd;
      rf_wdata <= aux_head.data;
      rf_src   <= 1'b1;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // FORCE is only entered while an aux result is waiting, and that result
  // cannot leave before the forced cycle drains it.
  a_force_has_entry: assert property (@(posedge clk) disable iff (reset)
    (state == FORCE) |-> aux_avail);

  a_single_grant: assert property (@(posedge clk) disable iff (reset)
    !(grant_pipe && grant_aux));

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  localparam int LIMIT = 4;

  bit          clk;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_ack;
  logic        aux_valid;
  logic [4:0]  aux_rd;
  logic [31:0] aux_data;
  logic        aux_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        rf_src;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .pipe_ack   (pipe_ack),
    .aux_valid  (aux_valid),
    .aux_rd     (aux_rd),
    .aux_data   (aux_data),
    .aux_ready  (aux_ready),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata),
    .rf_src     (rf_src)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the aux buffer is a queue, starvation is a count of
  // consecutive cycles in which a buffered result was passed over.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          m_force  = 0;
  int          m_denied = 0;
  logic        m_we     = 0;
  logic [4:0]  m_rd     = 0;
  logic [31:0] m_data   = 0;
  logic        m_src    = 0;

  always @(negedge clk) begin : model
    bit   ex_ready;
    bit   had;
    bit   g_pipe;
    bit   g_aux;
    ent_t h;

    ex_ready = !reset && (mq.size() < 2);
    chk("aux_ready", aux_ready, ex_ready);
    chk("pipe_ack", pipe_ack, pipe_valid && !m_force);
    chk("rf_we", rf_we, m_we);
    chk("rf_rd", rf_rd, m_rd);
    chk("rf_wdata", rf_wdata, m_data);
    chk("rf_src", rf_src, m_src);

    if (reset) begin
      mq.delete();
      m_force  = 0;
      m_denied = 0;
      m_we     = 0;
      m_rd     = 0;
      m_data   = 0;
      m_src    = 0;
    end else begin
      had    = (mq.size() > 0);
      g_pipe = 0;
      g_aux  = 0;
      if (m_force)         g_aux  = had;
      else if (pipe_valid) g_pipe = 1;
      else if (had)        g_aux  = 1;

      if (g_pipe) begin
        m_we = (pipe_rd != 0); m_rd = pipe_rd; m_data = pipe_data; m_src = 0;
      end else if (g_aux) begin
        h = mq.pop_front();
        m_we = (h.rd != 0); m_rd = h.rd; m_data = h.data; m_src = 1;
      end else begin
        m_we = 0;
      end

      if (had && !g_aux) begin
        m_denied++;
        m_force = (m_denied == LIMIT);
      end else begin
        m_denied = 0;
        m_force  = 0;
      end

      if (aux_valid && ex_ready) mq.push_back('{rd: aux_rd, data: aux_data});
    end
  end

  logic [4:0] order [3];
  int         got;
  bit         xfer;
  int         pv_pct;

  initial begin
    reset = 1; pipe_valid = 0; pipe_rd = 0; pipe_data = 0;
    aux_valid = 0; aux_rd = 0; aux_data = 0;
    for (int i = 0; i < 3; i++) order[i] = '0;

    // Reset state
    repeat (3) tick;
    #2;
    chk("reset_aux_ready", aux_ready, 0);
    chk("reset_rf_we", rf_we, 0);
    chk("reset_rf_rd", rf_rd, 0);
    chk("reset_rf_wdata", rf_wdata, 0);
    chk("reset_rf_src", rf_src, 0);
    tick; reset = 0;
    #2 chk("post_reset_aux_ready", aux_ready, 1);

    // Plain pipe write
    tick; pipe_valid = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF;
    #2 chk("pipe_ack", pipe_ack, 1);
    tick; pipe_valid = 0;
    #2;
    chk("pipe_we", rf_we, 1);
    chk("pipe_rd", rf_rd, 5);
    chk("pipe_wdata", rf_wdata, 32'hDEADBEEF);
    chk("pipe_src", rf_src, 0);

    // Write to x0 is consumed without a register write
    tick; pipe_valid = 1; pipe_rd = 0; pipe_data = 32'hFFFFFFFF;
    #2 chk("x0_ack", pipe_ack, 1);
    tick; pipe_valid = 0;
    #2;
    chk("x0_we", rf_we, 0);
    chk("x0_wdata", rf_wdata, 32'hFFFFFFFF);

    // Single aux result with the pipe idle
    tick; aux_valid = 1; aux_rd = 7; aux_data = 32'h11;
    #2 chk("aux_push_ready", aux_ready, 1);
    tick; aux_valid = 0;
    #2 chk("aux_pop_cycle_we", rf_we, 0);
    tick;
    #2;
    chk("aux_we", rf_we, 1);
    chk("aux_rd", rf_rd, 7);
    chk("aux_wdata", rf_wdata, 32'h11);
    chk("aux_src", rf_src, 1);

    // Starvation: one buffered aux entry against a saturated pipe
    tick; aux_valid = 1; aux_rd = 9; aux_data = 32'h99;
    pipe_valid = 1; pipe_rd = 1; pipe_data = 1;
    tick; aux_valid = 0;
    for (int i = 0; i < 4; i++) begin
      pipe_rd = 5'(10 + i); pipe_data = 32'(100 + i);
      #2;
      chk("starve_pipe_ack", pipe_ack, 1);
      chk("starve_pipe_src", rf_src, 0);
      tick;
    end
    pipe_rd = 20; pipe_data = 200;
    #2;
    chk("force_ack_low", pipe_ack, 0);
    chk("force_prev_rd", rf_rd, 13);
    tick;
    #2;
    chk("force_src", rf_src, 1);
    chk("force_rd", rf_rd, 9);
    chk("force_we", rf_we, 1);
    chk("resume_ack", pipe_ack, 1);
    tick; pipe_valid = 0;
    #2;
    chk("resume_rd", rf_rd, 20);
    chk("resume_src", rf_src, 0);

    // Three back-to-back aux pushes with the pipe saturated
    tick; pipe_valid = 1; pipe_rd = 6; pipe_data = 32'h66;
    aux_valid = 1; aux_rd = 2; aux_data = 32'h22;
    #2 chk("push1_ready", aux_ready, 1);
    tick; aux_rd = 3; aux_data = 32'h33;
    #2 chk("push2_ready", aux_ready, 1);
    tick; aux_rd = 4; aux_data = 32'h44;
    #2 chk("full_not_ready", aux_ready, 0);
    got = 0; xfer = 0;
    for (int c = 0; c < 60 && got < 3; c++) begin
      tick;
      if (xfer) begin aux_valid = 0; pipe_valid = 0; xfer = 0; end
      #2;
      if (rf_we && rf_src) begin order[got] = rf_rd; got++; end
      if (aux_valid && aux_ready) begin
        chk("held_until_pop", got, 1);
        xfer = 1;
      end
    end
    aux_valid = 0; pipe_valid = 0;
    chk("order_count", got, 3);
    chk("order_0", order[0], 2);
    chk("order_1", order[1], 3);
    chk("order_2", order[2], 4);

    // Reset pulse with two buffered aux entries
    tick; aux_valid = 1; aux_rd = 12; aux_data = 32'hC;
    pipe_valid = 1; pipe_rd = 8; pipe_data = 32'h8;
    tick; aux_rd = 13; aux_data = 32'hD;
    tick; aux_valid = 0; pipe_valid = 0; reset = 1;
    #2 chk("mid_reset_ready", aux_ready, 0);
    tick; reset = 0;
    #2;
    chk("after_reset_ready", aux_ready, 1);
    chk("after_reset_we", rf_we, 0);
    chk("after_reset_rd", rf_rd, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      #2 chk("no_aux_after_reset", rf_we, 0);
    end

    // Randomized traffic at several pipe loads
    for (int ph = 0; ph < 3; ph++) begin
      pv_pct = (ph == 0) ? 95 : ((ph == 1) ? 30 : 65);
      for (int c = 0; c < 1500; c++) begin
        tick;
        reset      = ($urandom_range(0, 199) == 0);
        pipe_valid = ($urandom_range(0, 99) < pv_pct);
        pipe_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        pipe_data  = $urandom;
        aux_valid  = ($urandom_range(0, 99) < 45);
        aux_rd     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        aux_data   = $urandom;
      end
    end

    tick; reset = 0; pipe_valid = 0; aux_valid = 0;
    repeat (6) tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
